uart_rx_os: RTL and testbench

Oversampling UART receiver: 16x oversampled serial input, 8 data bits LSB first, optional parity, one stop bit. It validates the start bit mid-bit and samples each data bit at its centre. It reports framing, parity and overrun errors. It is the receive end for the team's `uarttx`-style transmitter, replacing the fixed-rate receiver. Received bytes go out through a one-entry valid/ready holding register to the downstream consumer.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_rx_os.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_os.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling rate.
package uart_pkg;

    localparam int OS_RATE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HI
    } uart_rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: a one-clk pulse every DIV clocks, restartable
// with a synchronous clear so the receiver can phase-align to a start edge.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    // A divider below 2 cannot produce a distinct tick phase.
    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_baud_tick: DIV must be at least 2");
        end
    endgenerate

    assign tick = (cnt_reg == LAST);

    // Free-running modulo-DIV counter, restarted by reset or clear.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver, 8 data bits LSB first, optional parity,
// one stop bit, with a one-entry valid/ready holding register on the output.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 1536000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);
    localparam int         DIV         = CLK_FREQ / (BAUD_RATE * OS_RATE);
    localparam logic [3:0] MID_SAMPLE  = 4'(OS_RATE / 2 - 1);
    localparam logic [3:0] LAST_SAMPLE = 4'(OS_RATE - 1);
    localparam logic       PAR_EN      = (PARITY_EN != 0);
    localparam logic       PAR_ODD     = (PARITY_ODD != 0);

    logic [1:0]     sync_reg;
    logic           rx_s;
    logic           tick;
    logic           tick_clr;

    uart_rx_state_t state_reg, state_next;
    logic [3:0]     scnt_reg, scnt_next;
    logic [2:0]     bcnt_reg, bcnt_next;
    logic [7:0]     shift_reg, shift_next;
    logic           perr_reg, perr_next;
    logic           ferr_reg, ferr_next;
    logic           deliver_reg, deliver_next;

    logic [7:0]     rx_data_reg;
    logic           rx_valid_reg;
    logic           frame_err_reg;
    logic           parity_err_reg;
    logic           overrun_reg;
    logic           handshake;

    assign rx_s       = sync_reg[1];
    assign handshake  = rx_valid_reg && rx_ready;
    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != IDLE);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    // Frame state, counters and capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            scnt_reg    <= '0;
            bcnt_reg    <= '0;
            shift_reg   <= '0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            deliver_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            scnt_reg    <= scnt_next;
            bcnt_reg    <= bcnt_next;
            shift_reg   <= shift_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
            deliver_reg <= deliver_next;
        end
    end

    // Next-state logic: start validation at mid-bit, then one sample per bit
    // centre; the stop sample raises a one-cycle delivery request.
    always_comb begin
        state_next   = state_reg;
        scnt_next    = scnt_reg;
        bcnt_next    = bcnt_reg;
        shift_next   = shift_reg;
        perr_next    = perr_reg;
        ferr_next    = ferr_reg;
        deliver_next = 1'b0;
        tick_clr     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    scnt_next  = '0;
                    bcnt_next  = '0;
                    perr_next  = 1'b0;
                    tick_clr   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    scnt_next = scnt_reg + 4'd1;
                    if (scnt_reg == MID_SAMPLE) begin
                        scnt_next  = '0;
                        state_next = rx_s ? IDLE : DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    scnt_next = scnt_reg + 4'd1;
                    if (scnt_reg == LAST_SAMPLE) begin
                        shift_next = {rx_s, shift_reg[7:1]};
                        bcnt_next  = bcnt_reg + 3'd1;
                        if (bcnt_reg == 3'd7) begin
                            state_next = PAR_EN ? PARITY : STOP;
                        end
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    scnt_next = scnt_reg + 4'd1;
                    if (scnt_reg == LAST_SAMPLE) begin
                        perr_next  = ((^shift_reg) ^ rx_s) != PAR_ODD;
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    scnt_next = scnt_reg + 4'd1;
                    if (scnt_reg == LAST_SAMPLE) begin
                        ferr_next    = !rx_s;
                        deliver_next = 1'b1;
                        // A low stop bit may be a break; wait for the line to
                        // return high before hunting for a new start.
                        state_next   = rx_s ? IDLE : WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output holding register: load when empty or being drained this cycle,
    // otherwise drop the byte and flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else if (deliver_reg) begin
            if (!rx_valid_reg || handshake) begin
                rx_data_reg    <= shift_reg;
                frame_err_reg  <= ferr_reg;
                parity_err_reg <= perr_reg && PAR_EN;
                rx_valid_reg   <= 1'b1;
                if (handshake) begin
                    overrun_reg <= 1'b0;
                end
            end else begin
                overrun_reg <= 1'b1;
            end
        end else if (handshake) begin
            rx_valid_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: frame-level transmitter, event-driven model of the
// expected output slot, and a per-cycle compare against two DUT instances
// (8N1 and 8E1).
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam int DIV      = 10;
    localparam int BIT_CLKS = 16 * DIV;
    localparam int INF      = 32'h7fff_ffff;

    localparam int F_VALID = 0;
    localparam int F_DATA  = 1;
    localparam int F_FERR  = 2;
    localparam int F_PERR  = 3;
    localparam int F_OVR   = 4;
    localparam int F_BUSY  = 5;

    typedef struct {
        int         inst;
        int         at;
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } arr_t;

    typedef struct {
        int         inst;
        int         at;
        int         field;
        logic [7:0] val;
    } pin_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line    [2];
    logic       ready_line [2];
    logic       ready_fix  [2];
    bit         rand_ready = 1'b0;

    logic [7:0] d_data  [2];
    logic       d_valid [2];
    logic       d_ferr  [2];
    logic       d_perr  [2];
    logic       d_ovr   [2];
    logic       d_busy  [2];

    int         cyc = 0;
    bit         started = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    logic       m_valid [2];
    logic [7:0] m_data  [2];
    logic       m_ferr  [2];
    logic       m_perr  [2];
    logic       m_ovr   [2];
    int         busy_from [2];
    int         busy_to   [2];

    arr_t       arr_q [$];
    pin_t       pin_q [$];
    arr_t       cur_arr;
    pin_t       cur_pin;
    bit         got_arr;
    bit         hs_m;
    bit         exp_busy;

    always #5 clk = ~clk;

    uart_rx_os #(
        .CLK_FREQ(1536000), .BAUD_RATE(9600), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut0 (
        .clk(clk), .rst(rst), .rx(rx_line[0]),
        .rx_data(d_data[0]), .rx_valid(d_valid[0]), .rx_ready(ready_line[0]),
        .frame_err(d_ferr[0]), .parity_err(d_perr[0]),
        .overrun(d_ovr[0]), .busy(d_busy[0])
    );

    uart_rx_os #(
        .CLK_FREQ(1536000), .BAUD_RATE(9600), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut1 (
        .clk(clk), .rst(rst), .rx(rx_line[1]),
        .rx_data(d_data[1]), .rx_valid(d_valid[1]), .rx_ready(ready_line[1]),
        .frame_err(d_ferr[1]), .parity_err(d_perr[1]),
        .overrun(d_ovr[1]), .busy(d_busy[1])
    );

    function automatic string fname(input int f);
        case (f)
            F_VALID: return "rx_valid";
            F_DATA:  return "rx_data";
            F_FERR:  return "frame_err";
            F_PERR:  return "parity_err";
            F_OVR:   return "overrun";
            default: return "busy";
        endcase
    endfunction

    function automatic logic [7:0] dut_field(input int inst, input int f);
        case (f)
            F_VALID: return {7'd0, d_valid[inst]};
            F_DATA:  return d_data[inst];
            F_FERR:  return {7'd0, d_ferr[inst]};
            F_PERR:  return {7'd0, d_perr[inst]};
            F_OVR:   return {7'd0, d_ovr[inst]};
            default: return {7'd0, d_busy[inst]};
        endcase
    endfunction

    task automatic chk(input string name, input int inst, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, inst, cyc, got, exp);
        end
    endtask

    task automatic push_pin(input int inst, input int at, input int field, input logic [7:0] val);
        pin_t p;
        p.inst  = inst;
        p.at    = at;
        p.field = field;
        p.val   = val;
        pin_q.push_back(p);
    endtask

    task automatic idle_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Transmit one frame on instance inst (instance 1 carries a parity bit).
    // Registers the expected byte arrival and the busy window with the model.
    task automatic send_frame(input int inst, input logic [7:0] b, input logic par_bit,
                              input logic stop_bit, input int brk, input int gap);
        int   t0;
        int   p;
        arr_t a;
        p      = inst;
        t0     = cyc + 1;
        a.inst = inst;
        a.at   = t0 + 2 + (152 + 16 * p) * DIV + 1;
        a.data = b;
        a.ferr = !stop_bit;
        // Even parity: the data bits plus parity bit must hold an even count of ones.
        a.perr = (p != 0) && (($countones({b, par_bit}) % 2) != 0);
        arr_q.push_back(a);
        busy_from[inst] = t0 + 2;
        busy_to[inst]   = stop_bit ? t0 + 2 + (152 + 16 * p) * DIV : INF;
        rx_line[inst] = 1'b0;
        idle_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_line[inst] = b[i];
            idle_clks(BIT_CLKS);
        end
        if (p != 0) begin
            rx_line[inst] = par_bit;
            idle_clks(BIT_CLKS);
        end
        rx_line[inst] = stop_bit;
        idle_clks(BIT_CLKS);
        if (!stop_bit) begin
            idle_clks(brk);
            rx_line[inst] = 1'b1;
            busy_to[inst] = cyc + 3;
        end
        idle_clks(gap);
    endtask

    // Ready driver: fixed level, or random when the random phase asks for it.
    initial begin
        ready_line[0] = 1'b1;
        ready_line[1] = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ready_line[0] = rand_ready ? ($urandom_range(0, 3) == 0) : ready_fix[0];
            ready_line[1] = ready_fix[1];
        end
    end

    // Model update at each edge, then compare every output one step later.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            started = 1'b1;
            arr_q.delete();
            for (int i = 0; i < 2; i++) begin
                m_valid[i]   = 1'b0;
                m_data[i]    = 8'h00;
                m_ferr[i]    = 1'b0;
                m_perr[i]    = 1'b0;
                m_ovr[i]     = 1'b0;
                busy_from[i] = 0;
                busy_to[i]   = 0;
            end
        end else if (started) begin
            for (int i = 0; i < 2; i++) begin
                hs_m    = m_valid[i] && ready_line[i];
                got_arr = 1'b0;
                for (int k = arr_q.size() - 1; k >= 0; k--) begin
                    if (arr_q[k].inst == i && arr_q[k].at == cyc) begin
                        cur_arr = arr_q[k];
                        got_arr = 1'b1;
                        arr_q.delete(k);
                    end
                end
                if (got_arr) begin
                    if (!m_valid[i] || hs_m) begin
                        m_valid[i] = 1'b1;
                        m_data[i]  = cur_arr.data;
                        m_ferr[i]  = cur_arr.ferr;
                        m_perr[i]  = cur_arr.perr;
                        if (hs_m) m_ovr[i] = 1'b0;
                        $display("[%0d] dut%0d byte %02h ferr=%0b perr=%0b loaded", cyc, i,
                                 cur_arr.data, cur_arr.ferr, cur_arr.perr);
                    end else begin
                        m_ovr[i] = 1'b1;
                        $display("[%0d] dut%0d byte %02h dropped, overrun", cyc, i, cur_arr.data);
                    end
                end else if (hs_m) begin
                    m_valid[i] = 1'b0;
                    m_ovr[i]   = 1'b0;
                end
            end
        end
        #1;
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                exp_busy = (cyc >= busy_from[i]) && (cyc < busy_to[i]);
                chk("rx_valid", i, {7'd0, d_valid[i]}, {7'd0, m_valid[i]});
                chk("busy", i, {7'd0, d_busy[i]}, {7'd0, exp_busy});
                chk("overrun", i, {7'd0, d_ovr[i]}, {7'd0, m_ovr[i]});
                if (m_valid[i]) begin
                    chk("rx_data", i, d_data[i], m_data[i]);
                    chk("frame_err", i, {7'd0, d_ferr[i]}, {7'd0, m_ferr[i]});
                    chk("parity_err", i, {7'd0, d_perr[i]}, {7'd0, m_perr[i]});
                end
            end
            for (int k = pin_q.size() - 1; k >= 0; k--) begin
                if (pin_q[k].at == cyc) begin
                    cur_pin = pin_q[k];
                    pin_q.delete(k);
                    chk({"pin_", fname(cur_pin.field)}, cur_pin.inst,
                        dut_field(cur_pin.inst, cur_pin.field), cur_pin.val);
                end
            end
        end
    end

    initial begin
        int         t0;
        logic [7:0] b;
        logic       sb;
        rx_line[0]   = 1'b1;
        rx_line[1]   = 1'b1;
        ready_fix[0] = 1'b1;
        ready_fix[1] = 1'b1;
        rst          = 1'b1;

        // Reset values
        for (int f = 0; f < 6; f++) begin
            push_pin(0, 2, f, 8'h00);
            push_pin(1, 2, f, 8'h00);
        end
        idle_clks(3);
        rst = 1'b0;
        idle_clks(20);

        // 1: 0xA5 8N1, ready held high -> single-cycle valid at T0+1523
        t0 = cyc + 1;
        push_pin(0, t0 + 1522, F_VALID, 8'h00);
        push_pin(0, t0 + 1523, F_VALID, 8'h01);
        push_pin(0, t0 + 1523, F_DATA,  8'hA5);
        push_pin(0, t0 + 1523, F_FERR,  8'h00);
        push_pin(0, t0 + 1523, F_PERR,  8'h00);
        push_pin(0, t0 + 1524, F_VALID, 8'h00);
        send_frame(0, 8'hA5, 1'b0, 1'b1, 0, 40);

        // 2: 40-clk glitch, no byte, busy drops at T0+82
        t0 = cyc + 1;
        busy_from[0] = t0 + 2;
        busy_to[0]   = t0 + 82;
        push_pin(0, t0 + 81, F_BUSY, 8'h01);
        push_pin(0, t0 + 82, F_BUSY, 8'h00);
        rx_line[0] = 1'b0;
        idle_clks(40);
        rx_line[0] = 1'b1;
        idle_clks(200);

        // 3: 0x3C with low stop bit, 500-clk break, then clean 0x55
        t0 = cyc + 1;
        push_pin(0, t0 + 1523, F_DATA, 8'h3C);
        push_pin(0, t0 + 1523, F_FERR, 8'h01);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 500, 100);
        t0 = cyc + 1;
        push_pin(0, t0 + 1523, F_DATA, 8'h55);
        push_pin(0, t0 + 1523, F_FERR, 8'h00);
        send_frame(0, 8'h55, 1'b0, 1'b1, 0, 40);

        // 4: ready low, 0x11 then 0x22 -> 0x11 held with overrun, then drain
        ready_fix[0] = 1'b0;
        idle_clks(2);
        send_frame(0, 8'h11, 1'b0, 1'b1, 0, 20);
        t0 = cyc + 1;
        push_pin(0, t0 + 1523, F_VALID, 8'h01);
        push_pin(0, t0 + 1523, F_DATA,  8'h11);
        push_pin(0, t0 + 1523, F_OVR,   8'h01);
        send_frame(0, 8'h22, 1'b0, 1'b1, 0, 20);
        ready_fix[0] = 1'b1;
        push_pin(0, cyc + 1, F_VALID, 8'h00);
        push_pin(0, cyc + 1, F_OVR,   8'h00);
        idle_clks(1);
        ready_fix[0] = 1'b0;
        idle_clks(10);
        ready_fix[0] = 1'b1;
        idle_clks(10);

        // 5: even parity on dut1, 0x07 with wrong then right parity bit
        t0 = cyc + 1;
        push_pin(1, t0 + 1683, F_DATA, 8'h07);
        push_pin(1, t0 + 1683, F_PERR, 8'h01);
        send_frame(1, 8'h07, 1'b0, 1'b1, 0, 40);
        t0 = cyc + 1;
        push_pin(1, t0 + 1683, F_DATA, 8'h07);
        push_pin(1, t0 + 1683, F_PERR, 8'h00);
        send_frame(1, 8'h07, 1'b1, 1'b1, 0, 40);

        // 6: reset during data bit 4 of 0xFF, then clean 0x5A
        t0 = cyc + 1;
        busy_from[0] = t0 + 2;
        busy_to[0]   = INF;
        rx_line[0] = 1'b0;
        idle_clks(BIT_CLKS);
        rx_line[0] = 1'b1;
        idle_clks(BIT_CLKS * 4 + BIT_CLKS / 2);
        rst = 1'b1;
        for (int f = 0; f < 6; f++) push_pin(0, cyc + 1, f, 8'h00);
        idle_clks(1);
        rst = 1'b0;
        idle_clks(100);
        t0 = cyc + 1;
        push_pin(0, t0 + 1523, F_DATA, 8'h5A);
        push_pin(0, t0 + 1523, F_FERR, 8'h00);
        push_pin(0, t0 + 1523, F_PERR, 8'h00);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 0, 40);

        // Random phase: random bytes, occasional breaks, random ready
        rand_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 5) != 0);
            send_frame(0, b, 1'b0, sb, $urandom_range(0, 300), $urandom_range(5, 200));
        end
        rand_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom);
            send_frame(1, b, 1'($urandom_range(0, 1)), 1'b1, 0, $urandom_range(5, 100));
        end
        idle_clks(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
